// File: rtl/pipelined_io_device.sv
// Board-side I/O for the pipelined computer: debounced switches/keys in, 3 ports out as 2-digit 7-seg.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero tens digit on numeric ports.
//
// state     | meaning
// CAPTURE   | latch out_port[k], pick dash or start conversion
// DIV       | subtract 10 per cycle until remainder < 10
// WRITE     | drive hex pair k, advance k, pulse frame_done after pair 2
module pipelined_io_device #(
    parameter int DB_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [9:0]  sw,
    input  logic [3:1]  key_n,
    input  logic [31:0] out_port0,
    input  logic [31:0] out_port1,
    input  logic [31:0] out_port2,
    output logic [31:0] in_port0,
    output logic [31:0] in_port1,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        frame_done
);

    localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYCLES - 1);
    localparam logic [12:0]   IN_RST   = {3'b111, 10'b0};
    localparam logic [6:0]    SEG_DASH = 7'b0111111;
    localparam logic [6:0]    SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {
        S_CAPTURE,
        S_DIV,
        S_WRITE
    } state_t;

    logic [12:0]   raw_in;
    logic [12:0]   sync1;
    logic [12:0]   sync2;
    logic [12:0]   db;
    logic [CW-1:0] db_cnt [13];
    logic          key1_q;
    logic [7:0]    press_cnt;
    logic          key1_fall;

    state_t        state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic [6:0]    rem_q, rem_d;
    logic [3:0]    tens_q, tens_d;
    logic          dash_q, dash_d;
    logic [5:0][6:0] hex_q, hex_d;
    logic          frame_d;
    logic [31:0]   v;
    logic [6:0]    tens_seg;
    logic [6:0]    ones_seg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    assign raw_in = {key_n, sw};

    // Each bit debounces on its own counter; keys reset released so no phantom press appears.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= IN_RST;
            sync2 <= IN_RST;
            db    <= IN_RST;
            for (int i = 0; i < 13; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            for (int i = 0; i < 13; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign key1_fall = key1_q & ~db[10];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key1_q    <= 1'b1;
            press_cnt <= '0;
            in_port0  <= '0;
            in_port1  <= '0;
        end else begin
            key1_q   <= db[10];
            if (key1_fall) press_cnt <= press_cnt + 8'd1;
            in_port0 <= {22'b0, db[9:0]};
            in_port1 <= {16'b0, press_cnt, 5'b0, ~db[12:10]};
        end
    end

    always_comb begin
        case (k_q)
            2'd0:    v = out_port0;
            2'd1:    v = out_port1;
            default: v = out_port2;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign tens_seg = dash_q ? SEG_DASH : ((tens_q == 4'd0) ? SEG_OFF : seg7(tens_q));
`else
    assign tens_seg = dash_q ? SEG_DASH : seg7(tens_q);
`endif
    assign ones_seg = dash_q ? SEG_DASH : seg7(rem_q[3:0]);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rem_d   = rem_q;
        tens_d  = tens_q;
        dash_d  = dash_q;
        hex_d   = hex_q;
        frame_d = 1'b0;
        case (state_q)
            S_CAPTURE: begin
                if (v > 32'd99) begin
                    dash_d  = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    dash_d  = 1'b0;
                    rem_d   = v[6:0];
                    tens_d  = 4'd0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (rem_q >= 7'd10) begin
                    rem_d  = rem_q - 7'd10;
                    tens_d = tens_q + 4'd1;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                case (k_q)
                    2'd0: begin
                        hex_d[0] = ones_seg;
                        hex_d[1] = tens_seg;
                    end
                    2'd1: begin
                        hex_d[2] = ones_seg;
                        hex_d[3] = tens_seg;
                    end
                    default: begin
                        hex_d[4] = ones_seg;
                        hex_d[5] = tens_seg;
                    end
                endcase
                frame_d = (k_q == 2'd2);
                k_d     = (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
                state_d = S_CAPTURE;
            end
            default: state_d = S_CAPTURE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_CAPTURE;
            k_q        <= '0;
            rem_q      <= '0;
            tens_q     <= '0;
            dash_q     <= 1'b0;
            hex_q      <= {6{SEG_OFF}};
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            rem_q      <= rem_d;
            tens_q     <= tens_d;
            dash_q     <= dash_d;
            hex_q      <= hex_d;
            frame_done <= frame_d;
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_pipelined_io_device.sv
// Self-checking bench for pipelined_io_device: directed stimulus plus a per-cycle display model check.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_pipelined_io_device;

    localparam int DB = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clock;
    logic        resetn;
    logic [9:0]  sw;
    logic [3:1]  key_n;
    logic [31:0] out_port0, out_port1, out_port2;
    logic [31:0] in_port0, in_port1;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    pipelined_io_device #(.DB_CYCLES(DB)) dut (
        .clock(clock), .resetn(resetn), .sw(sw), .key_n(key_n),
        .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
        .in_port0(in_port0), .in_port1(in_port1),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Display model: what a pair must show for a port value, and what the port costs in cycles.
    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[d];
    endfunction

    function automatic logic [13:0] pair_of(input logic [31:0] v);
        int t, o;
        logic [6:0] ts;
        if (v > 32'd99) return {7'b0111111, 7'b0111111};
        t  = int'(v) / 10;
        o  = int'(v) % 10;
        ts = (LZB && t == 0) ? 7'h7F : seg_of(t);
        return {ts, seg_of(o)};
    endfunction

    function automatic int cost_of(input logic [31:0] v);
        return (v > 32'd99) ? 2 : int'(v) / 10 + 3;
    endfunction

    // Per-cycle compare: reset values while in reset; at each frame_done of a frame that began
    // after the ports last changed, all six digits and the frame length must match the model.
    initial begin
        logic [95:0] last_ports;
        int frames, cyc, last_pulse;
        last_ports = '0;
        frames = 0;
        cyc = 0;
        last_pulse = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!resetn) begin
                check("rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h7F}});
                check("rst_in0", in_port0, 32'h0);
                check("rst_in1", in_port1, 32'h0);
                check("rst_fd", {31'b0, frame_done}, 32'h0);
                frames = 0;
            end else begin
                if ({out_port2, out_port1, out_port0} != last_ports) begin
                    last_ports = {out_port2, out_port1, out_port0};
                    frames = 0;
                end
                check("in0_rsvd", {10'b0, in_port0[31:10]}, 32'h0);
                check("in1_rsvd", {8'b0, in_port1[31:16], in_port1[7:3], 3'b0}, 32'h0);
                if (frame_done) begin
                    if (frames >= 1) begin
                        check("pair0", {18'b0, hex1, hex0}, {18'b0, pair_of(out_port0)});
                        check("pair1", {18'b0, hex3, hex2}, {18'b0, pair_of(out_port1)});
                        check("pair2", {18'b0, hex5, hex4}, {18'b0, pair_of(out_port2)});
                        check("frame_len", cyc - last_pulse,
                              cost_of(out_port0) + cost_of(out_port1) + cost_of(out_port2));
                    end
                    frames++;
                    last_pulse = cyc;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_pulses(input int n, input int limit, output int gap);
        int seen, c, last;
        seen = 0; c = 0; last = 0; gap = 0;
        while (seen < n && c < limit) begin
            @(posedge clock);
            #1;
            c++;
            if (frame_done) begin
                seen++;
                gap  = c - last;
                last = c;
            end
        end
        check("pulse_wait", seen, n);
        #1;
    endtask

    task automatic press_key1();
        key_n = 3'b110;
        step(8);
        key_n = 3'b111;
        step(8);
    endtask

    initial begin
        int gap;
        int found;
        resetn = 1'b0;
        sw = '0;
        key_n = 3'b111;
        out_port0 = '0; out_port1 = '0; out_port2 = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_hex0", hex0, 7'h7F);
        check("reset_hex5", hex5, 7'h7F);
        check("reset_in0", in_port0, 32'h0);
        check("reset_in1", in_port1, 32'h0);
        check("reset_fd", frame_done, 0);
        step(1);
        resetn = 1'b1;

        sw = 10'h2A5;
        step(8);
        check("sw_2a5", in_port0, 32'h0000_02A5);
        sw = 10'h2A4;
        step(2);
        sw = 10'h2A5;
        step(10);
        check("sw_glitch", in_port0, 32'h0000_02A5);

        for (int i = 0; i < 3; i++) begin
            key_n = 3'b110;
            step(8);
            check("key1_held", in_port1[0], 1);
            key_n = 3'b111;
            step(8);
        end
        check("press_3", in_port1, 32'h0000_0300);
        for (int i = 0; i < 252; i++) press_key1();
        check("press_255", in_port1[15:8], 8'd255);
        press_key1();
        check("press_wrap", in_port1[15:8], 8'd0);

        sw = 10'h155;
        key_n = 3'b010;
        step(8);
        check("simul_sw", in_port0, 32'h0000_0155);
        check("simul_key", in_port1, 32'h0000_0105);
        key_n = 3'b111;
        step(8);
        check("simul_rel", in_port1, 32'h0000_0100);

        out_port0 = 32'd37; out_port1 = 32'd100; out_port2 = 32'd5;
        wait_pulses(2, 80, gap);
        check("hex1_37", hex1, 7'b0110000);
        check("hex0_37", hex0, 7'b1111000);
        check("hex3_100", hex3, 7'b0111111);
        check("hex2_100", hex2, 7'b0111111);
        check("hex4_5", hex4, 7'b0010010);
        check("hex5_5", hex5, LZB ? 7'b1111111 : 7'b1000000);
        check("frame_11", gap, 11);

        out_port0 = 32'd0; out_port1 = 32'd99; out_port2 = 32'hFFFF_FFFF;
        wait_pulses(2, 80, gap);
        check("hex1_0", hex1, LZB ? 7'h7F : 7'b1000000);
        check("hex0_0", hex0, 7'b1000000);
        check("hex3_99", hex3, 7'b0010000);
        check("hex2_99", hex2, 7'b0010000);
        check("hex5_big", hex5, 7'b0111111);
        check("frame_17", gap, 17);

        out_port0 = 32'd99;
        wait_pulses(2, 80, gap);
        check("pre_rst_hex0", hex0, 7'b0010000);
        wait_pulses(1, 40, gap);
        @(posedge clock);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("middiv_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h7F}});
        check("middiv_fd", frame_done, 0);
        check("middiv_in0", in_port0, 32'h0);
        step(2);
        resetn = 1'b1;
        found = 0;
        for (int c = 0; c < 36 && found == 0; c++) begin
            @(posedge clock);
            #1;
            if (hex1 == 7'b0010000 && hex0 == 7'b0010000) found = 1;
        end
        check("post_rst_99", found, 1);
        step(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipelined_io_device.md
Name: pipelined_io_device

Overview:
Board-side end of the pipelined computer's memory-mapped I/O ports. Debounces raw switches and keys and supplies them to the CPU as in_port0/in_port1. Consumes the CPU's out_port0..2 and renders each as two decimal digits on six 7-segment displays, using a sequential divide-by-10 scanner. Sits at top level between the DE2 pins and the computer core.

Parameters:
DB_CYCLES, 50000, consecutive stable synchronized cycles required before a debounced input changes (use a small value such as 4 in simulation).

Ports:
clock  in  1  system clock; all logic on posedge
resetn  in  1  asynchronous active-low reset
sw  in  10  raw slide switches
key_n  in  3  raw push-buttons KEY[3:1], active-low
out_port0  in  32  CPU output port 0
out_port1  in  32  CPU output port 1
out_port2  in  32  CPU output port 2
in_port0  out  32  to CPU: debounced switches
in_port1  out  32  to CPU: key levels and key1 press count
hex0..hex5  out  7 each  active-low segments, bit6=g .. bit0=a
frame_done  out  1  one-cycle pulse after hex5:hex4 are written

Behaviour:
Reset values:
- hex0..hex5 = 7'h7F (blank).
- in_port0 = 0; in_port1 = 0.
- frame_done = 0.
- Debounced sw = 0; debounced key_n = 3'b111.
- Press count = 0; scanner state = CAPTURE with k = 0.

Input path, per bit (13 bits):
- Two-flop synchronizer feeds a debounce counter.
- Counter clears whenever the synced value equals the debounced value.
- Counter increments otherwise; on reaching DB_CYCLES-1 the debounced value takes the synced value and the counter clears.
- A glitch shorter than DB_CYCLES never propagates.
- in_port0 = {22'b0, sw_db}, registered; it updates on the cycle after sw_db changes.
- in_port1 = {16'b0, press_cnt[7:0], 5'b0, ~key_n_db[3:1]}, registered.
- press_cnt increments by 1 on each 1->0 transition of key_n_db[1]; it wraps 255 -> 0.

Output scanner FSM. Port k = 0, 1, 2 maps to hex pair (1:0), (3:2), (5:4). States:
- CAPTURE (1 cycle):
  - Latch v = out_port[k].
  - If v > 99 unsigned: set dash = 1 and go to WRITE.
  - Else: rem = v[6:0], tens = 0, go to DIV.
- DIV, each cycle:
  - If rem >= 10: rem -= 10, tens += 1.
  - Else: go to WRITE.
- WRITE (1 cycle):
  - If dash: both digits of pair k = 7'b0111111.
  - Else: tens digit = seg(tens), ones digit = seg(rem).
  - If k == 2: pulse frame_done.
  - Set k = (k==2) ? 0 : k+1, then go to CAPTURE.

Timing:
- Cycles per port = floor(v/10) + 3 for v <= 99 (worst case 12); 2 for dash.
- Full frame <= 36 cycles.

Segment encoding seg(0..9): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.

Boundaries:
- An out_port change during conversion does not affect the in-flight digit; it is picked up on the next visit to that port.
- v = 99 and v = 100 are the two edges; v = 0 shows "00".
- Reset asserted mid-DIV returns all outputs to reset values immediately; after release, scanning restarts at k = 0.
- Simultaneous key_n and sw changes debounce independently.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: a tens digit of 0 on a non-dash port is written as 7'h7F (blank).
- Undefined: the tens digit always shows seg(tens), including "0".

Test Plan:
- Reset, DB_CYCLES=4 -> all hex = 7'h7F, in_port0 = 0, in_port1 = 0, frame_done = 0.
- sw = 10'h2A5 held for 8 cycles -> in_port0 = 32'h000002A5. A 2-cycle pulse sw[0]=0 afterwards -> in_port0 unchanged.
- Press and release key_n[1] three times, 8 cycles each phase -> in_port1[15:8] = 3 and in_port1[0] = 1 while held. After 256 presses total -> count = 0.
- out_port0 = 37 -> within 36 cycles hex1 = 0110000, hex0 = 1111000; frame_done pulses once per frame.
- out_port1 = 100 -> hex3 = hex2 = 0111111.
- out_port2 = 5 -> hex4 = 0010010; hex5 = 1000000 without the macro, 1111111 with LEADING_ZERO_BLANK_EN.
- out_port0 = 99, assert resetn low during DIV -> hex blank within the same cycle. After release -> hex1 = hex0 = 0010000 within 36 cycles.
